fadd_hp_sched: RTL and testbench

//  Round-robin scheduler that shares one combinational FAdder_HalfPrecision datapath between NUM_REQ requesters.
//  Per requester: valid/ready request channel. Shared: one valid/ready response channel.

---
 rtl/fadd_hp_sched_if.sv | 52 +++++
 rtl/fadd_hp_sched.sv | 158 +++++++++++++++
 tb/tb_fadd_hp_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fadd_hp_sched_if.sv
// Signal bundle between fadd_hp_sched, its FP16 clients, the shared adder
// and the result consumer.
//
// Handshake rule for every valid/ready pair (req_valid[i]/req_ready[i] and
// resp_valid/resp_ready): a transfer happens on a rising clk edge where both
// valid and ready are 1. The sender keeps its payload stable while valid=1
// and ready=0. A requester may drop valid before ready and simply loses the
// grant. resp_valid, once raised, stays high with stable payload until taken.
interface fadd_hp_sched_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_add;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;

    logic                  fa_add;
    logic [15:0]           fa_a;
    logic [15:0]           fa_b;
    logic [15:0]           fa_sum;
    logic                  fa_ovf;
    logic                  fa_unf;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [15:0]           resp_sum;
    logic                  resp_ovf;
    logic                  resp_unf;

    // Environment side: clients, adder instance and result consumer.
    modport master (
        output req_valid, req_add, req_a, req_b,
        input  req_ready,
        input  fa_add, fa_a, fa_b,
        output fa_sum, fa_ovf, fa_unf,
        input  resp_valid, resp_id, resp_sum, resp_ovf, resp_unf,
        output resp_ready
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_add, req_a, req_b,
        output req_ready,
        output fa_add, fa_a, fa_b,
        input  fa_sum, fa_ovf, fa_unf,
        output resp_valid, resp_id, resp_sum, resp_ovf, resp_unf,
        input  resp_ready
    );
endinterface

// File: rtl/fadd_hp_sched.sv
// Round-robin scheduler sharing one combinational FP16 adder between NUM_REQ
// requesters. One operation in flight: grant in IDLE, hold operands for
// ADDER_LATENCY cycles in WAIT, present the captured result in RESP.
module fadd_hp_sched #(
    parameter int NUM_REQ       = 2,
    parameter int ADDER_LATENCY = 1,
    parameter int ID_W          = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fadd_hp_sched_if.slave        bus,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [3:0]          cnt;

    logic                op_add;
    logic [15:0]         op_a;
    logic [15:0]         op_b;

    logic                resp_valid_q;
    logic [ID_W-1:0]     resp_id_q;
    logic [15:0]         resp_sum_q;
    logic                resp_ovf_q;
    logic                resp_unf_q;

    logic                lo_found;
    logic [ID_W-1:0]     lo_idx;
    logic                hi_found;
    logic [ID_W-1:0]     hi_idx;
    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     ptr_next;

    logic                sel_add;
    logic [15:0]         sel_a;
    logic [15:0]         sel_b;
    logic [NUM_REQ-1:0]  req_ready_c;

    // Round-robin pick: lowest valid index at or above rr_ptr, otherwise
    // wrap around to the lowest valid index overall.
    always_comb begin
        lo_found = 1'b0;
        lo_idx   = '0;
        hi_found = 1'b0;
        hi_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
            end
            if (bus.req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
                hi_found = 1'b1;
                hi_idx   = ID_W'(i);
            end
        end
        grant_found = lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
        ptr_next    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_add = 1'b0;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_add = bus.req_add[i];
                sel_a   = bus.req_a[16*i +: 16];
                sel_b   = bus.req_b[16*i +: 16];
            end
        end
    end

    // Grant strobe: only in IDLE, and forced low while reset is asserted so
    // no accept is advertised before the first edge after reset.
    always_comb begin
        req_ready_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_c[i] = rst_n && (state == S_IDLE) && grant_found &&
                             (grant_idx == ID_W'(i));
        end
    end

    // Control FSM with registered operands and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            cnt          <= '0;
            op_add       <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
            resp_ovf_q   <= 1'b0;
            resp_unf_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        op_add    <= sel_add;
                        op_a      <= sel_a;
                        op_b      <= sel_b;
                        resp_id_q <= grant_idx;
                        rr_ptr    <= ptr_next;
                        cnt       <= 4'(ADDER_LATENCY);
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Adder has had ADDER_LATENCY cycles to settle on the
                    // held operands when cnt reaches 1.
                    if (cnt == 4'd1) begin
                        resp_sum_q   <= bus.fa_sum;
                        resp_ovf_q   <= bus.fa_ovf;
                        resp_unf_q   <= bus.fa_unf;
                        resp_valid_q <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.fa_add     = op_add;
    assign bus.fa_a       = op_a;
    assign bus.fa_b       = op_b;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_sum   = resp_sum_q;
    assign bus.resp_ovf   = resp_ovf_q;
    assign bus.resp_unf   = resp_unf_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_fadd_hp_sched.sv
// Bench for fadd_hp_sched: FP16 adder stand-in with settle latency, vector
// table, hand-written corner sequences and a randomized run against a
// cycle-level reference model.
module tb_fadd_hp_sched;
    localparam int NUM_REQ = 3;
    localparam int LAT     = 3;
    localparam int ID_W    = 2;
    localparam int W       = ID_W + 18;   // {id, ovf, unf, sum}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fadd_hp_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();
    logic [1:0] dbg_state;

    fadd_hp_sched #(.NUM_REQ(NUM_REQ), .ADDER_LATENCY(LAT), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- FP16 arithmetic reference ----------------
    function automatic real pow2(int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp_val(logic [15:0] h);
        real m;
        if (h[14:10] == 5'd0) m = real'(h[9:0]) * pow2(-24);
        else m = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
        return h[15] ? -m : m;
    endfunction

    // Returns {ovf, unf, sum}; truncating rounding, flush-to-zero underflow.
    function automatic logic [17:0] fp_add_ref(logic add, logic [15:0] a, logic [15:0] b);
        real r, m;
        int e;
        logic s;
        logic [9:0] man;
        r = add ? fp_val(a) + fp_val(b) : fp_val(a) - fp_val(b);
        s = (r < 0.0);
        m = s ? -r : r;
        if (m == 0.0) return 18'h0;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        if (e + 15 >= 31) return {1'b1, 1'b0, s, 5'h1F, 10'h0};
        if (e + 15 <= 0)  return {1'b0, 1'b1, s, 15'h0};
        man = 10'($rtoi((m - 1.0) * 1024.0));
        return {2'b00, s, 5'(e + 15), man};
    endfunction

    // ---------------- adder stand-in ----------------
    // Output is only correct once the operands have been stable long enough;
    // before that it presents the complement so early capture is visible.
    logic [32:0] fa_prev   = '0;
    int          fa_stable = 0;
    logic [17:0] fa_good;
    always @(negedge clk) begin
        if ({bus.fa_add, bus.fa_a, bus.fa_b} != fa_prev) begin
            fa_prev   <= {bus.fa_add, bus.fa_a, bus.fa_b};
            fa_stable <= 0;
        end else begin
            fa_stable <= fa_stable + 1;
        end
    end
    always_comb fa_good = fp_add_ref(bus.fa_add, bus.fa_a, bus.fa_b);
    assign bus.fa_sum = (fa_stable >= LAT - 1) ? fa_good[15:0] : ~fa_good[15:0];
    assign bus.fa_ovf = (fa_stable >= LAT - 1) ? fa_good[17]   : ~fa_good[17];
    assign bus.fa_unf = (fa_stable >= LAT - 1) ? fa_good[16]   : ~fa_good[16];

    // ---------------- driver tasks ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_op(int i, logic add, logic [15:0] a, logic [15:0] b);
        bus.req_add[i]       = add;
        bus.req_a[16*i +: 16] = a;
        bus.req_b[16*i +: 16] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One operation from a single requester with resp_ready=1.
    task automatic run_one(int r, logic add, logic [15:0] a, logic [15:0] b, logic [17:0] exp);
        int lat;
        set_op(r, add, a, b);
        bus.req_valid    = '0;
        bus.req_valid[r] = 1'b1;
        bus.resp_ready   = 1'b1;
        #1;
        check("tbl_grant", bus.req_ready, 32'(1 << r));
        tick();
        bus.req_valid = '0;
        lat = 0;
        while (!bus.resp_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("tbl_latency", lat, LAT);
        check("tbl_id", bus.resp_id, r);
        check("tbl_sum", bus.resp_sum, exp[15:0]);
        check("tbl_ovf", bus.resp_ovf, exp[17]);
        check("tbl_unf", bus.resp_unf, exp[16]);
        tick();
        check("tbl_release", bus.resp_valid, 0);
        check("tbl_idle", dbg_state, 0);
    endtask

    typedef struct {
        logic        add;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[7];
    logic [15:0] rot_exp[NUM_REQ];
    int gcnt[NUM_REQ];
    logic cur_add[NUM_REQ];
    logic [15:0] cur_a[NUM_REQ];
    logic [15:0] cur_b[NUM_REQ];

    initial begin
        int nresp, cyc, n, g, m_ptr, m_resp_at, regen;
        bit m_busy, m_resp;
        logic [NUM_REQ-1:0] v, exp_rdy;
        logic [W-1:0] e;

        vecs[0] = '{1'b1, 16'h3C00, 16'h3C00, 16'h4000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'h4000, 16'h3C00, 16'h3C00, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 16'h7BFF, 16'h7BFF, 16'h7C00, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 16'h3C00, 16'h3C00, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 16'h0401, 16'h0400, 16'h0000, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 16'hC000, 16'h3C00, 16'hBC00, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 16'h4200, 16'h3C00, 16'h4400, 1'b0, 1'b0};

        // Reset state, checked before the first clock edge.
        rst_n          = 1'b0;
        bus.req_valid  = '1;
        bus.req_add    = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        #2;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_sum", bus.resp_sum, 0);
        check("rst_resp_id", bus.resp_id, 0);
        check("rst_flags", {bus.resp_ovf, bus.resp_unf}, 0);
        check("rst_operands", {bus.fa_add, bus.fa_a, bus.fa_b}, 0);
        bus.req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // Vector table; requesters visited 0,2,1,... so the lone requester
        // must win whatever rr_ptr holds.
        for (int k = 0; k < 7; k++) begin
            run_one((k * 2) % NUM_REQ, vecs[k].add, vecs[k].a, vecs[k].b,
                    {vecs[k].ovf, vecs[k].unf, vecs[k].sum});
        end

        // All requesters valid continuously: grants rotate 0,1,2,0,1,2.
        do_reset();
        set_op(0, 1'b1, 16'h3C00, 16'h3C00); rot_exp[0] = 16'h4000;
        set_op(1, 1'b0, 16'h4000, 16'h3C00); rot_exp[1] = 16'h3C00;
        set_op(2, 1'b1, 16'hC000, 16'h3C00); rot_exp[2] = 16'hBC00;
        for (int i = 0; i < NUM_REQ; i++) gcnt[i] = 0;
        bus.req_valid  = '1;
        bus.resp_ready = 1'b1;
        nresp = 0;
        cyc   = 0;
        while (nresp < 6 && cyc < 200) begin
            #1;
            for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) gcnt[i]++;
            if (bus.resp_valid) begin
                check("rot_id", bus.resp_id, nresp % NUM_REQ);
                check("rot_sum", bus.resp_sum, rot_exp[nresp % NUM_REQ]);
                nresp++;
            end
            if (nresp == 6) bus.req_valid = '0;
            tick();
            cyc++;
        end
        check("rot_count", nresp, 6);
        for (int i = 0; i < NUM_REQ; i++) check("rot_grant_cycles", gcnt[i], 2);

        // Response stall: everything held, no grants, then IDLE next cycle.
        bus.req_valid  = '1;
        bus.resp_ready = 1'b0;
        #1;
        check("stall_grant", bus.req_ready, 3'b001);
        n = 0;
        while (!bus.resp_valid && n < 50) begin
            tick();
            n++;
        end
        check("stall_latency", n, LAT + 1);
        for (int k = 0; k < 10; k++) begin
            check("stall_valid", bus.resp_valid, 1);
            check("stall_id", bus.resp_id, 0);
            check("stall_sum", bus.resp_sum, 16'h4000);
            check("stall_no_grant", bus.req_ready, 0);
            tick();
        end
        bus.resp_ready = 1'b1;
        tick();
        check("stall_release", bus.resp_valid, 0);
        check("stall_next_grant", bus.req_ready, 3'b010);
        bus.req_valid = '0;
        tick();

        // Reset while an op is in WAIT.
        set_op(0, 1'b1, 16'h3C00, 16'h3C00);
        bus.req_valid = 3'b001;
        #1;
        check("rstw_grant", bus.req_ready, 3'b001);
        tick();
        bus.req_valid = '0;
        tick();
        check("rstw_in_wait", dbg_state, 1);
        set_op(0, 1'b1, 16'h4000, 16'h4000);
        bus.req_valid = '1;
        rst_n = 1'b0;
        #1;
        check("rstw_resp_valid", bus.resp_valid, 0);
        check("rstw_req_ready", bus.req_ready, 0);
        check("rstw_operands", bus.fa_a, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rstw_first_grant", bus.req_ready, 3'b001);
        bus.req_valid = 3'b001;
        tick();
        bus.req_valid = '0;
        n = 0;
        while (!bus.resp_valid && n < 40) begin
            tick();
            n++;
        end
        check("rstw_latency", n, LAT);
        check("rstw_id", bus.resp_id, 0);
        check("rstw_sum", bus.resp_sum, 16'h4400);
        tick();

        // Randomized run against the reference model.
        do_reset();
        m_ptr  = 0;
        m_busy = 1'b0;
        m_resp_at = 0;
        regen  = -1;
        exp_q.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            cur_add[i] = 1'($urandom_range(0, 1));
            cur_a[i]   = 16'($urandom_range(0, 16'hFFFF));
            cur_b[i]   = 16'($urandom_range(0, 16'hFFFF));
            set_op(i, cur_add[i], cur_a[i], cur_b[i]);
        end
        for (int c = 0; c < 640; c++) begin
            if (regen >= 0) begin
                cur_add[regen] = 1'($urandom_range(0, 1));
                cur_a[regen]   = 16'($urandom_range(0, 16'hFFFF));
                cur_b[regen]   = 16'($urandom_range(0, 16'hFFFF));
                set_op(regen, cur_add[regen], cur_a[regen], cur_b[regen]);
                regen = -1;
            end
            for (int i = 0; i < NUM_REQ; i++) v[i] = (c < 600) && ($urandom_range(0, 3) != 0);
            bus.req_valid  = v;
            bus.resp_ready = (c >= 600) || ($urandom_range(0, 2) != 0);
            #1;
            exp_rdy = '0;
            g = 0;
            if (!m_busy) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (exp_rdy == '0 && v[(m_ptr + k) % NUM_REQ]) begin
                        g = (m_ptr + k) % NUM_REQ;
                        exp_rdy[g] = 1'b1;
                    end
                end
            end
            m_resp = m_busy && (c >= m_resp_at);
            check("rnd_req_ready", bus.req_ready, exp_rdy);
            check("rnd_resp_valid", bus.resp_valid, m_resp);
            if (m_resp && exp_q.size() > 0) begin
                e = exp_q[0];
                if (bus.resp_id !== e[W-1:18] || bus.resp_ovf !== e[17] ||
                    bus.resp_unf !== e[16] || bus.resp_sum !== e[15:0]) begin
                    check("rnd_resp", {bus.resp_id, bus.resp_ovf, bus.resp_unf, bus.resp_sum}, e);
                end else begin
                    n_checks++;
                end
                if (bus.resp_ready) begin
                    void'(exp_q.pop_front());
                    m_busy = 1'b0;
                end
            end
            if (exp_rdy != '0) begin
                exp_q.push_back({ID_W'(g), fp_add_ref(cur_add[g], cur_a[g], cur_b[g])});
                m_busy    = 1'b1;
                m_resp_at = c + LAT + 1;
                m_ptr     = (g + 1) % NUM_REQ;
                regen     = g;
            end
            tick();
        end
        check("rnd_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
